// File: rtl/pe_vec_pkg.sv
// ---------------------------------------------------------------------------
// pe_vec_pkg
// Shared definitions for the vector MAC processing element.
//   mode_e   : operating mode encoding on mode_in (11 behaves as PASS)
//   state_e  : control FSM state encoding
//   sat_hi / sat_lo : saturation bounds for a signed word of a given width;
//                     the ReLU floor is zero and needs no constant
//   eff_mode : folds the reserved encoding onto PASS
// ---------------------------------------------------------------------------
package pe_vec_pkg;

  typedef enum logic [1:0] {
    MODE_MAC     = 2'b00,
    MODE_MAXPOOL = 2'b01,
    MODE_PASS    = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OUT  = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  localparam int UNIT_ID_BITS = 8;

  function automatic logic signed [63:0] sat_hi(input int word_bits);
    return (64'sd1 <<< (word_bits - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_lo(input int word_bits);
    return -(64'sd1 <<< (word_bits - 1));
  endfunction

  function automatic mode_e eff_mode(input logic [1:0] m);
    return (m == MODE_RSVD) ? MODE_PASS : mode_e'(m);
  endfunction

endpackage

// File: rtl/pe_vec_mac_lane.sv
// ---------------------------------------------------------------------------
// pe_lane
// One output channel of the vector MAC: accumulator plus emit datapath.
// Ports:
//   CLK, RST        clock, asynchronous active-low reset
//   clr_i           synchronous clear of the accumulator (layer done)
//   lane_en_i       lane enable; disabled lane outputs 0 and holds acc
//   accept_i        an input beat is consumed this cycle
//   emit_i          a result is produced this cycle
//   mode_i          effective mode (MAC / MAXPOOL / PASS)
//   relu_en_i       clamp negative results to zero
//   shift_i         arithmetic right shift applied to MAC results
//   pix_i, w_i      signed pixel and shared weight
//   bias_i          signed bias added to MAC results
//   res_o           saturated result word (combinational, valid on emit)
// ---------------------------------------------------------------------------
module pe_lane
  import pe_vec_pkg::*;
#(
  parameter int WORD_BITS = 16,
  parameter int ACC_BITS  = 40
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        clr_i,
  input  logic                        lane_en_i,
  input  logic                        accept_i,
  input  logic                        emit_i,
  input  mode_e                       mode_i,
  input  logic                        relu_en_i,
  input  logic [4:0]                  shift_i,
  input  logic signed [WORD_BITS-1:0] pix_i,
  input  logic signed [WORD_BITS-1:0] w_i,
  input  logic signed [WORD_BITS-1:0] bias_i,
  output logic [WORD_BITS-1:0]        res_o
);

  localparam logic signed [ACC_BITS-1:0] SAT_HI  = ACC_BITS'(sat_hi(WORD_BITS));
  localparam logic signed [ACC_BITS-1:0] SAT_LO  = ACC_BITS'(sat_lo(WORD_BITS));
  localparam logic signed [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  logic signed [ACC_BITS-1:0]    acc_q, acc_d;
  logic signed [2*WORD_BITS-1:0] prod;
  logic signed [ACC_BITS-1:0]    prod_ext, pix_ext, bias_ext;
  logic signed [ACC_BITS-1:0]    acc_upd;   // accumulator including this cycle's beat
  logic signed [ACC_BITS-1:0]    emit_val;  // value before ReLU/saturation
  logic signed [ACC_BITS-1:0]    clamp_val;

  assign prod     = w_i * pix_i;
  assign prod_ext = {{(ACC_BITS-2*WORD_BITS){prod[2*WORD_BITS-1]}}, prod};
  assign pix_ext  = {{(ACC_BITS-WORD_BITS){pix_i[WORD_BITS-1]}}, pix_i};
  assign bias_ext = {{(ACC_BITS-WORD_BITS){bias_i[WORD_BITS-1]}}, bias_i};

  always_comb begin
    acc_upd  = acc_q;
    emit_val = acc_q;
    unique case (mode_i)
      MODE_MAC: begin
        acc_upd  = accept_i ? (acc_q + prod_ext) : acc_q;
        emit_val = (acc_upd + bias_ext) >>> shift_i;
      end
      MODE_MAXPOOL: begin
        acc_upd  = (accept_i && (pix_ext > acc_q)) ? pix_ext : acc_q;
        emit_val = acc_upd;
      end
      default: begin
        acc_upd  = accept_i ? pix_ext : acc_q;
        emit_val = acc_upd;
      end
    endcase
  end

  // ReLU first, then saturate into the signed word range.
  always_comb begin
    clamp_val = emit_val;
    if (relu_en_i && emit_val[ACC_BITS-1]) begin
      clamp_val = '0;
    end
    if (!lane_en_i) begin
      res_o = '0;
    end else if (clamp_val > SAT_HI) begin
      res_o = SAT_HI[WORD_BITS-1:0];
    end else if (clamp_val < SAT_LO) begin
      res_o = SAT_LO[WORD_BITS-1:0];
    end else begin
      res_o = clamp_val[WORD_BITS-1:0];
    end
  end

  // After an emit the window restarts: MAC from zero, MAXPOOL from the
  // most negative value so the first beat always wins. PASS keeps the load.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (lane_en_i) begin
      if (emit_i) begin
        unique case (mode_i)
          MODE_MAC:     acc_d = '0;
          MODE_MAXPOOL: acc_d = ACC_MIN;
          default:      acc_d = acc_upd;
        endcase
      end else if (accept_i) begin
        acc_d = acc_upd;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/pe_vec_mac.sv
// ---------------------------------------------------------------------------
// pe_vec_mac
// Vector processing element: LANES parallel MAC / max-pool / pass channels
// sharing one weight, with a registered output stage and store addressing.
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   En_in                 compute enable (output handshake runs regardless)
//   layer_done_in         synchronous clear, highest priority
//   mode_in               00 MAC, 01 MAXPOOL, 10/11 PASS
//   relu_en_in, shift_in  post-processing controls
//   lane_en_in            per-lane enable
//   store_base_in         base added to the write counter for out_addr
//   in_valid/in_ready     input beat handshake; pix_in per lane, w_in shared
//   bias_valid_in/bias_in end-of-window strobe and per-lane bias
//   out_valid/out_ready   output handshake; out_data, out_addr, out_unit
// ---------------------------------------------------------------------------
module pe_vec_mac
  import pe_vec_pkg::*;
#(
  parameter int UNIT_NO   = 0,
  parameter int WORD_BITS = 16,
  parameter int LANES     = 4,
  parameter int ACC_BITS  = 40,
  parameter int ADDR_BITS = 6
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         En_in,
  input  logic                         layer_done_in,
  input  logic [1:0]                   mode_in,
  input  logic                         relu_en_in,
  input  logic [4:0]                   shift_in,
  input  logic [LANES-1:0]             lane_en_in,
  input  logic [ADDR_BITS-1:0]         store_base_in,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES*WORD_BITS-1:0]   pix_in,
  input  logic [WORD_BITS-1:0]         w_in,
  input  logic                         bias_valid_in,
  input  logic [LANES*WORD_BITS-1:0]   bias_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [LANES*WORD_BITS-1:0]   out_data,
  output logic [ADDR_BITS-1:0]         out_addr,
  output logic [UNIT_ID_BITS-1:0]      out_unit
);

  logic                       out_valid_q;
  logic [LANES*WORD_BITS-1:0] out_data_q;
  logic [LANES*WORD_BITS-1:0] lane_res;
  logic [ADDR_BITS-1:0]       wr_cnt_q;
  state_e                     state_q, state_d;
  mode_e                      mode_eff;
  logic                       accept, emit, out_fire;

  assign mode_eff = eff_mode(mode_in);

  // Stall new work only while a result is waiting on a blocked consumer.
  assign in_ready = ~(out_valid_q & ~out_ready);
  assign accept   = in_valid & in_ready & En_in & ~layer_done_in;
  // PASS emits on every accepted beat; the bias strobe needs no in_valid.
  assign emit     = En_in & in_ready & ~layer_done_in &
                    (bias_valid_in | (accept & (mode_eff == MODE_PASS)));
  assign out_fire = out_valid_q & out_ready;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    pe_lane #(
      .WORD_BITS (WORD_BITS),
      .ACC_BITS  (ACC_BITS)
    ) u_lane (
      .CLK       (CLK),
      .RST       (RST),
      .clr_i     (layer_done_in),
      .lane_en_i (lane_en_in[gi]),
      .accept_i  (accept),
      .emit_i    (emit),
      .mode_i    (mode_eff),
      .relu_en_i (relu_en_in),
      .shift_i   (shift_in),
      .pix_i     (pix_in[gi*WORD_BITS +: WORD_BITS]),
      .w_i       (w_in),
      .bias_i    (bias_in[gi*WORD_BITS +: WORD_BITS]),
      .res_o     (lane_res[gi*WORD_BITS +: WORD_BITS])
    );
  end

  // Output stage. An emit can only happen when the slot is free or being
  // drained this cycle, so loading over a valid result never loses data.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_cnt_q    <= '0;
    end else if (layer_done_in) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wr_cnt_q    <= '0;
    end else begin
      if (out_fire) begin
        wr_cnt_q <= wr_cnt_q + ADDR_BITS'(1);
      end
      if (emit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= lane_res;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  // Control FSM; it tracks window progress and freezes while En_in is low.
  always_comb begin
    state_d = state_q;
    if (layer_done_in) begin
      state_d = ST_IDLE;
    end else if (En_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (emit)        state_d = ST_OUT;
          else if (accept) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (emit) state_d = ST_OUT;
        end
        ST_OUT: begin
          if (emit)           state_d = ST_OUT;
          else if (out_ready) state_d = ST_RUN;
          else                state_d = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) state_d = emit ? ST_OUT : ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_addr  = store_base_in + wr_cnt_q;
  assign out_unit  = UNIT_ID_BITS'(UNIT_NO);

endmodule

// File: tb/tb_pe_vec_mac.sv
module tb_pe_vec_mac;

  localparam longint ACC_MIN = -(64'sd1 <<< 39);

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        En_in = 1'b1;
  logic        layer_done_in = 1'b0;
  logic [1:0]  mode_in = 2'b00;
  logic        relu_en_in = 1'b0;
  logic [4:0]  shift_in = 5'd0;
  logic [3:0]  lane_en_in = 4'hF;
  logic [5:0]  store_base_in = 6'd5;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] pix_in = '0;
  logic [15:0] w_in = '0;
  logic        bias_valid_in = 1'b0;
  logic [63:0] bias_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [5:0]  out_addr;
  logic [7:0]  out_unit;

  int checks = 0;
  int errors = 0;

  // Reference model state
  longint acc_m [4];
  longint data_m [4];
  bit     valid_m;
  int     cnt_m;

  pe_vec_mac #(
    .UNIT_NO   (37),
    .WORD_BITS (16),
    .LANES     (4),
    .ACC_BITS  (40),
    .ADDR_BITS (6)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .En_in         (En_in),
    .layer_done_in (layer_done_in),
    .mode_in       (mode_in),
    .relu_en_in    (relu_en_in),
    .shift_in      (shift_in),
    .lane_en_in    (lane_en_in),
    .store_base_in (store_base_in),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .pix_in        (pix_in),
    .w_in          (w_in),
    .bias_valid_in (bias_valid_in),
    .bias_in       (bias_in),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr),
    .out_unit      (out_unit)
  );

  initial forever #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint lane_out(input int l);
    return longint'($signed(out_data[l*16 +: 16]));
  endfunction

  task automatic chk_out(input string tag, input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    for (int l = 0; l < 4; l++) chk($sformatf("%s.lane%0d", tag, l), lane_out(l), e[l]);
  endtask

  function automatic longint sat_word(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic model_reset();
    for (int l = 0; l < 4; l++) begin acc_m[l] = 0; data_m[l] = 0; end
    valid_m = 0;
    cnt_m = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_edge();
    bit rdy, beat, em;
    longint pv, p, bv, nxt, v, after;
    rdy  = !(valid_m && !out_ready);
    beat = in_valid && rdy && En_in && !layer_done_in;
    em   = !layer_done_in && En_in && rdy && (bias_valid_in || (beat && mode_in[1]));
    if (layer_done_in) begin
      model_reset();
      return;
    end
    if (valid_m && out_ready) cnt_m = (cnt_m + 1) % 64;
    if (em) valid_m = 1;
    else if (out_ready) valid_m = 0;
    for (int l = 0; l < 4; l++) begin
      pv = longint'($signed(pix_in[l*16 +: 16]));
      bv = longint'($signed(bias_in[l*16 +: 16]));
      p  = pv * longint'($signed(w_in));
      if (!lane_en_in[l]) begin
        if (em) data_m[l] = 0;
      end else begin
        if (mode_in == 2'b00) begin
          nxt   = beat ? acc_m[l] + p : acc_m[l];
          v     = (nxt + bv) >>> shift_in;
          after = em ? 0 : nxt;
        end else if (mode_in == 2'b01) begin
          nxt   = (beat && pv > acc_m[l]) ? pv : acc_m[l];
          v     = nxt;
          after = em ? ACC_MIN : nxt;
        end else begin
          nxt   = beat ? pv : acc_m[l];
          v     = nxt;
          after = nxt;
        end
        if (em) begin
          if (relu_en_in && v < 0) v = 0;
          data_m[l] = sat_word(v);
        end
        acc_m[l] = after;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pix(input int a, input int b, input int c, input int d);
    pix_in = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic set_bias(input int v);
    bias_in = {4{16'(v)}};
  endtask

  task automatic beat();
    in_valid = 1'b1; tick(); in_valid = 1'b0;
  endtask

  task automatic emit_b(input int b);
    set_bias(b); bias_valid_in = 1'b1; tick(); bias_valid_in = 1'b0;
  endtask

  task automatic ld_pulse();
    layer_done_in = 1'b1; tick(); layer_done_in = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset state
    #2;
    chk("rst.in_ready", in_ready, 1);
    chk("rst.out_valid", out_valid, 0);
    chk("rst.out_data", out_data, 0);
    chk("rst.out_addr", out_addr, 5);
    store_base_in = 6'd9;
    #1;
    chk("rst.addr_follow", out_addr, 9);
    chk("unit", out_unit, 37);
    RST = 1'b1;

    // MAC: 3 beats, w=2, bias=1
    set_pix(1, 2, 3, 4); w_in = 16'd2;
    beat(); beat(); beat();
    emit_b(1);
    chk("mac.valid", out_valid, 1);
    chk_out("mac", 7, 13, 19, 25);
    chk("mac.addr", out_addr, 9);

    // Saturation and ReLU
    set_pix(32767, 32767, 32767, 32767); w_in = 16'd32767;
    beat(); emit_b(0);
    chk_out("sat.pos", 32767, 32767, 32767, 32767);
    set_pix(-32767, -32767, -32767, -32767);
    beat(); emit_b(0);
    chk_out("sat.neg", -32768, -32768, -32768, -32768);
    relu_en_in = 1'b1;
    beat(); emit_b(0);
    chk_out("sat.relu", 0, 0, 0, 0);
    relu_en_in = 1'b0;

    // Lane enable: disabled lane outputs 0 and keeps its accumulator
    set_pix(10, 10, 10, 10); w_in = 16'd1;
    beat();
    lane_en_in = 4'b0111;
    emit_b(0);
    chk_out("lane_dis", 10, 10, 10, 0);
    lane_en_in = 4'hF;
    emit_b(0);
    chk_out("lane_keep", 0, 0, 0, 10);

    // Arithmetic shift
    shift_in = 5'd2;
    set_pix(-9, -9, 9, 9);
    beat(); emit_b(0);
    chk_out("shift", -3, -3, 2, 2);
    shift_in = 5'd0;

    // MAXPOOL: two windows
    ld_pulse();
    mode_in = 2'b01;
    set_pix(-5, -5, -5, -5); beat();
    set_pix(9, 9, 9, 9);     beat();
    set_pix(3, 3, 3, 3);     beat();
    emit_b(0);
    chk_out("maxp.w1", 9, 9, 9, 9);
    set_pix(-7, -7, -7, -7); beat();
    set_pix(-2, -2, -2, -2); beat();
    emit_b(0);
    chk_out("maxp.w2", -2, -2, -2, -2);

    // PASS and reserved mode
    mode_in = 2'b10;
    set_pix(100, -100, 32767, -32768); beat();
    chk("pass.valid", out_valid, 1);
    chk_out("pass", 100, -100, 32767, -32768);
    mode_in = 2'b11;
    set_pix(1, 2, 3, 4); beat();
    chk_out("rsvd", 1, 2, 3, 4);

    // Backpressure
    mode_in = 2'b00;
    ld_pulse();
    set_pix(1, 2, 3, 4); w_in = 16'd1;
    beat();
    out_ready = 1'b0;
    emit_b(0);
    chk("bp.valid", out_valid, 1);
    in_valid = 1'b1; bias_valid_in = 1'b1; set_pix(50, 50, 50, 50);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("bp.in_ready%0d", i), in_ready, 0);
      chk($sformatf("bp.valid%0d", i), out_valid, 1);
      chk_out($sformatf("bp.hold%0d", i), 1, 2, 3, 4);
      chk($sformatf("bp.addr%0d", i), out_addr, 9);
    end
    in_valid = 1'b0; bias_valid_in = 1'b0; out_ready = 1'b1;
    #1;
    chk("bp.release_ready", in_ready, 1);
    tick();
    chk("bp.after_valid", out_valid, 0);
    chk("bp.after_addr", out_addr, 10);
    emit_b(0);
    chk_out("bp.no_accept", 0, 0, 0, 0);
    chk("bp.next_addr", out_addr, 10);

    // Address wrap
    store_base_in = 6'd60;
    ld_pulse();
    set_bias(0); bias_valid_in = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("wrap.valid%0d", k), out_valid, 1);
      chk($sformatf("wrap.addr%0d", k), out_addr, (60 + k) % 64);
    end
    bias_valid_in = 1'b0;
    tick();
    chk("wrap.end_valid", out_valid, 0);
    chk("wrap.end_addr", out_addr, 2);

    // layer_done beats a simultaneous bias strobe
    store_base_in = 6'd20;
    set_pix(5, 5, 5, 5); w_in = 16'd3;
    beat(); beat();
    layer_done_in = 1'b1; bias_valid_in = 1'b1;
    tick();
    layer_done_in = 1'b0; bias_valid_in = 1'b0;
    chk("ld.valid", out_valid, 0);
    chk("ld.addr", out_addr, 20);
    emit_b(0);
    chk_out("ld.acc", 0, 0, 0, 0);
    chk("ld.emit_addr", out_addr, 20);

    // En_in low: compute frozen, handshake still completes
    out_ready = 1'b0;
    emit_b(0);
    En_in = 1'b0; out_ready = 1'b1;
    in_valid = 1'b1; bias_valid_in = 1'b1; set_pix(7, 7, 7, 7); w_in = 16'd1;
    tick();
    in_valid = 1'b0; bias_valid_in = 1'b0;
    chk("en.valid", out_valid, 0);
    chk("en.addr", out_addr, 21);
    En_in = 1'b1;
    emit_b(0);
    chk_out("en.frozen", 0, 0, 0, 0);

    // Asynchronous reset mid-window
    ld_pulse();
    set_pix(4, 4, 4, 4); w_in = 16'd1;
    beat(); beat();
    out_ready = 1'b0;
    emit_b(0);
    chk("arst.pre_valid", out_valid, 1);
    #2 RST = 1'b0;
    model_reset();
    #1;
    chk("arst.valid", out_valid, 0);
    chk("arst.in_ready", in_ready, 1);
    chk("arst.data", out_data, 0);
    chk("arst.addr", out_addr, 20);
    #2 RST = 1'b1;
    out_ready = 1'b1;
    set_pix(1, 1, 1, 1);
    beat(); emit_b(0);
    chk_out("arst.fresh", 1, 1, 1, 1);

    // Randomized segments checked against the model every cycle
    for (int seg = 0; seg < 4; seg++) begin
      mode_in = 2'(seg);
      store_base_in = 6'($urandom_range(0, 63));
      relu_en_in = 1'b0; En_in = 1'b1; out_ready = 1'b1;
      in_valid = 1'b0; bias_valid_in = 1'b0;
      ld_pulse();
      for (int c = 0; c < 50; c++) begin
        in_valid      = 1'($urandom_range(0, 1));
        En_in         = ($urandom_range(0, 9) != 0);
        bias_valid_in = ($urandom_range(0, 3) == 0);
        out_ready     = ($urandom_range(0, 3) != 0);
        layer_done_in = ($urandom_range(0, 49) == 0);
        relu_en_in    = 1'($urandom_range(0, 1));
        lane_en_in    = 4'($urandom);
        shift_in      = 5'($urandom_range(0, 6));
        pix_in        = {$urandom(), $urandom()};
        bias_in       = {$urandom(), $urandom()};
        w_in          = 16'($urandom);
        #1;
        chk($sformatf("rnd%0d.%0d.in_ready", seg, c), in_ready, !(valid_m && !out_ready));
        tick();
        chk($sformatf("rnd%0d.%0d.valid", seg, c), out_valid, valid_m);
        chk($sformatf("rnd%0d.%0d.addr", seg, c), out_addr, (int'(store_base_in) + cnt_m) % 64);
        if (valid_m) begin
          for (int l = 0; l < 4; l++)
            chk($sformatf("rnd%0d.%0d.lane%0d", seg, c, l), lane_out(l), data_m[l]);
        end
      end
      layer_done_in = 1'b0;
      lane_en_in = 4'hF;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
